bram_flush_sequencer: RTL and testbench
=======================================

Name: bram_flush_sequencer

Overview:
Active end of the BRAM flush option. When the flush input of a BRAM tile is not tied to constant 0, this block drives the flush. On request it takes over the BRAM write port and writes FILL_VALUE to every address from 0 to DEPTH-1, then signals completion. When idle it passes the user write port through with one register stage. It sits between the user-side write interface and the BRAM primitive inside the BRAM logical tile.

Parameters:
ADDR_WIDTH, 10, width of the BRAM address bus.
DATA_WIDTH, 32, width of the BRAM data bus.
DEPTH, 1024, number of words flushed; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
FILL_VALUE, 0, data word written to every address during a flush.

Ports:
clk  input  1  fabric clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
flush_req  input  1  level request, sampled only in IDLE.
flush_hold  input  1  when 1, pauses the flush address walk.
flush_busy  output  1  high while a flush is in progress.
flush_done  output  1  one-cycle pulse when a flush completes.
user_wen  input  1  user write enable.
user_addr  input  ADDR_WIDTH  user write address.
user_wdata  input  DATA_WIDTH  user write data.
user_stall  output  1  combinational; equals flush_req OR flush_busy. A user write offered while this is high is dropped.
bram_wen  output  1  registered BRAM write enable.
bram_addr  output  ADDR_WIDTH  registered BRAM address.
bram_wdata  output  DATA_WIDTH  registered BRAM write data.

Behaviour:
- Reset: state = IDLE. flush_busy, flush_done, bram_wen = 0. bram_addr, bram_wdata = 0. Internal address counter = 0. Reset has priority over every other input.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If flush_req = 1: next state WRITE, counter = 0. User write that cycle is dropped.
  - Otherwise: bram_wen/addr/wdata register user_wen/addr/wdata. User path latency is exactly 1 cycle.
- WRITE:
  - flush_busy = 1.
  - If flush_hold = 0: bram_wen = 1, bram_addr = counter, bram_wdata = FILL_VALUE. Counter increments.
  - If flush_hold = 1: bram_wen = 0 and the counter is frozen. Addresses are never skipped or repeated.
  - The cycle that issues address DEPTH-1 transitions to DONE. The counter does not wrap.
- DONE:
  - Lasts exactly 1 cycle. flush_done = 1, flush_busy = 1, bram_wen = 0.
  - Next state IDLE.
- Timing: with flush_hold = 0, the first flush write appears on the bram_* outputs the cycle after flush_req is sampled. The sequence is exactly DEPTH write cycles followed by one DONE cycle.
- flush_req held high through DONE starts a new flush on the first IDLE cycle after DONE. flush_req changes during WRITE/DONE are ignored.
- DEPTH = 1: a single write to address 0, then DONE.
- Reset mid-flush: immediate return to IDLE, no flush_done pulse. The partially flushed contents stay in the BRAM.
- user_wen with user_stall = 1: never reaches the BRAM. No error is flagged.

Optional Feature:
BRAM_FLUSH_VERIFY_EN:
- Defined:
  - Adds a VERIFY state between WRITE and DONE.
  - Adds ports: bram_ren output 1, bram_rdata input DATA_WIDTH (read latency 1 cycle), flush_error output 1.
  - VERIFY reads addresses 0 to DEPTH-1 (flush_hold pauses it the same way as in WRITE) and compares each returned word with FILL_VALUE.
  - Any mismatch sets flush_error. flush_error stays set until the next accepted flush_req or reset.
  - DONE is entered one cycle after the last read data returns.
- Not defined: none of these ports or states exist, and flush latency is DEPTH + 1 cycles.

Test Plan:
- Reset, then user_wen = 1, addr = 5, data = 0xA5A5A5A5 in IDLE -> the next cycle shows bram_wen = 1, bram_addr = 5, bram_wdata = 0xA5A5A5A5; user_stall = 0.
- DEPTH = 16, flush_req pulse -> 16 consecutive cycles with bram_wen = 1, addresses 0..15, data 0; then flush_done high for 1 cycle; flush_busy high for 17 cycles.
- DEPTH = 16, flush_hold = 1 for 3 cycles while the counter is at 7 -> bram_wen = 0 for those cycles, resumes at address 7, total flush span 20 cycles.
- flush_req and user_wen both 1 in IDLE -> user_stall = 1, no user write issued, and the flush starts at address 0.
- Reset asserted when the counter is at 9 -> the next cycle has all outputs 0 and state IDLE, with no flush_done pulse.
- With BRAM_FLUSH_VERIFY_EN, bram_rdata forced to 0x1 at address 3 -> flush_error = 1 after VERIFY, then cleared by the next flush_req.

Source files
------------

// File: rtl/bram_flush_sequencer.sv
// -----------------------------------------------------------------------------
// bram_flush_sequencer
//
// Purpose:
//   This block drives the flush of a BRAM tile. On request it takes over the
//   BRAM write port and writes FILL_VALUE to addresses 0..DEPTH-1, then pulses
//   flush_done. When no flush is running it passes the user write port through
//   to the BRAM with one register stage.
//
// Optional feature (compile-time macro):
//   BRAM_FLUSH_VERIFY_EN - adds a VERIFY pass after the write walk. VERIFY
//   reads back every flushed word and flags any word that differs from
//   FILL_VALUE on flush_error_o. It also adds bram_ren_o, bram_rdata_i and
//   flush_error_o. The default build (macro undefined) has none of these.
//
// Ports:
//   clk_i          fabric clock, rising edge
//   reset_i        synchronous, active-high reset
//   flush_req_i    level request, sampled only while idle
//   flush_hold_i   pauses the flush address walk while high
//   flush_busy_o   high while a flush is in progress (including the done cycle)
//   flush_done_o   one-cycle completion pulse
//   user_wen_i     user write enable
//   user_addr_i    user write address
//   user_wdata_i   user write data
//   user_stall_o   flush_req_i | flush_busy_o; user writes offered while this
//                  is high are dropped
//   bram_wen_o     registered BRAM write enable
//   bram_addr_o    registered BRAM address
//   bram_wdata_o   registered BRAM write data
//   bram_ren_o     (verify build) registered BRAM read enable
//   bram_rdata_i   (verify build) BRAM read data, valid one cycle after bram_ren_o
//   flush_error_o  (verify build) sticky read-back mismatch flag
//
// Timing:
//   The bram_* outputs are registered. Decisions (including the effect of
//   flush_hold_i) are taken from inputs sampled at a rising edge and become
//   visible on the outputs right after that edge. With flush_hold_i low, the
//   flush shows DEPTH consecutive write cycles starting the cycle after
//   flush_req_i is sampled, followed by one done cycle.
// -----------------------------------------------------------------------------
module bram_flush_sequencer #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_req_i,
  input  logic                  flush_hold_i,
  output logic                  flush_busy_o,
  output logic                  flush_done_o,
  input  logic                  user_wen_i,
  input  logic [ADDR_WIDTH-1:0] user_addr_i,
  input  logic [DATA_WIDTH-1:0] user_wdata_i,
  output logic                  user_stall_o,
  output logic                  bram_wen_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_wdata_o
`ifdef BRAM_FLUSH_VERIFY_EN
  ,
  output logic                  bram_ren_o,
  input  logic [DATA_WIDTH-1:0] bram_rdata_i,
  output logic                  flush_error_o
`endif
);

  // The counter holds the number of addresses already issued, so it needs one
  // extra bit to represent DEPTH itself when DEPTH == 2**ADDR_WIDTH.
  localparam int               CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // WRITE stays entered while the last issued write is on the outputs; the
  // walk is finished once the counter has reached DEPTH.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
`ifdef BRAM_FLUSH_VERIFY_EN
    ,
    VERIFY = 2'd3
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bram_wen_q, bram_wen_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]   bram_wdata_q, bram_wdata_d;
  logic                    writeStep;

`ifdef BRAM_FLUSH_VERIFY_EN
  logic                    bram_ren_q, bram_ren_d;
  logic                    rvalid_q;
  logic                    error_q, error_d;
  logic                    readStep;
`endif

  // Next-state logic. writeStep (and readStep in the verify build) marks a
  // cycle in which the walk may issue the next address; flush_hold_i turns
  // that cycle into a bubble without advancing the counter, so addresses are
  // never skipped or repeated.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bram_wen_d   = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    writeStep    = 1'b0;
`ifdef BRAM_FLUSH_VERIFY_EN
    bram_ren_d   = 1'b0;
    error_d      = error_q;
    readStep     = 1'b0;
    // Read data returns the cycle after the read was presented.
    if (rvalid_q && (bram_rdata_i != FILL_VALUE)) begin
      error_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          // The user write offered this cycle is dropped; the flush walk
          // issues address 0 straight away.
          state_d   = WRITE;
          cnt_d     = '0;
          writeStep = 1'b1;
`ifdef BRAM_FLUSH_VERIFY_EN
          error_d   = 1'b0;
`endif
        end else begin
          bram_wen_d   = user_wen_i;
          bram_addr_d  = user_addr_i;
          bram_wdata_d = user_wdata_i;
        end
      end

      WRITE: begin
        if (cnt_q == DEPTH_C) begin
`ifdef BRAM_FLUSH_VERIFY_EN
          state_d  = VERIFY;
          cnt_d    = '0;
          readStep = 1'b1;
`else
          state_d  = DONE;
`endif
        end else begin
          writeStep = 1'b1;
        end
      end

`ifdef BRAM_FLUSH_VERIFY_EN
      VERIFY: begin
        // Once every read has been issued, wait for the last read to be
        // returned (ren no longer on the outputs) before finishing.
        if (cnt_q == DEPTH_C) begin
          if (!bram_ren_q) begin
            state_d = DONE;
          end
        end else begin
          readStep = 1'b1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (writeStep && !flush_hold_i) begin
      bram_wen_d   = 1'b1;
      bram_addr_d  = cnt_d[ADDR_WIDTH-1:0];
      bram_wdata_d = FILL_VALUE;
      cnt_d        = cnt_d + ONE_C;
    end

`ifdef BRAM_FLUSH_VERIFY_EN
    if (readStep && !flush_hold_i) begin
      bram_ren_d  = 1'b1;
      bram_addr_d = cnt_d[ADDR_WIDTH-1:0];
      cnt_d       = cnt_d + ONE_C;
    end
`endif
  end

  // State, counter and BRAM port registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bram_wen_q   <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bram_wen_q   <= bram_wen_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

`ifdef BRAM_FLUSH_VERIFY_EN
  // Read-back tracking: rvalid_q marks the cycle the BRAM returns a word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bram_ren_q <= 1'b0;
      rvalid_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      bram_ren_q <= bram_ren_d;
      rvalid_q   <= bram_ren_q;
      error_q    <= error_d;
    end
  end

  assign bram_ren_o    = bram_ren_q;
  assign flush_error_o = error_q;
`endif

  assign flush_busy_o = (state_q != IDLE);
  assign flush_done_o = (state_q == DONE);
  assign user_stall_o = flush_req_i | flush_busy_o;
  assign bram_wen_o   = bram_wen_q;
  assign bram_addr_o  = bram_addr_q;
  assign bram_wdata_o = bram_wdata_q;

endmodule

// File: tb/tb_bram_flush_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bram_flush_sequencer
//
// Self-checking bench for bram_flush_sequencer (default build, verify feature
// off). Directed scenarios cover the user pass-through, a plain flush, a held
// flush, a request colliding with a user write, reset mid-flush and a request
// held through the done cycle. A randomized run is checked against a
// queue-based reference model: an accepted request loads the list of
// addresses still to be written, each sampled cycle either pops one address
// (hold low) or inserts a bubble (hold high), and an empty list produces the
// done cycle.
// -----------------------------------------------------------------------------
module tb_bram_flush_sequencer;

  localparam int          AW    = 10;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] FILL  = 32'h5A5A_0F0F;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          flush_req_i;
  logic          flush_hold_i;
  logic          flush_busy_o;
  logic          flush_done_o;
  logic          user_wen_i;
  logic [AW-1:0] user_addr_i;
  logic [DW-1:0] user_wdata_i;
  logic          user_stall_o;
  logic          bram_wen_o;
  logic [AW-1:0] bram_addr_o;
  logic [DW-1:0] bram_wdata_o;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int            mQ[$];
  bit            mFlushing;
  bit            mInDone;
  logic          eWen;
  logic          eBusy;
  logic          eDone;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eData;

  bram_flush_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .FILL_VALUE(FILL)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_req_i (flush_req_i),
    .flush_hold_i(flush_hold_i),
    .flush_busy_o(flush_busy_o),
    .flush_done_o(flush_done_o),
    .user_wen_i  (user_wen_i),
    .user_addr_i (user_addr_i),
    .user_wdata_i(user_wdata_i),
    .user_stall_o(user_stall_o),
    .bram_wen_o  (bram_wen_o),
    .bram_addr_o (bram_addr_o),
    .bram_wdata_o(bram_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  // One rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: advance one rising edge given the inputs sampled there.
  task automatic modelStep(input bit rst, input bit req, input bit hold,
                           input bit uw, input logic [AW-1:0] ua,
                           input logic [DW-1:0] ud);
    int nextAddr;
    if (rst) begin
      mQ.delete();
      mFlushing = 0;
      mInDone   = 0;
      eWen = 0; eBusy = 0; eDone = 0; eAddr = '0; eData = '0;
    end else if (mInDone) begin
      mInDone = 0;
      eWen = 0; eBusy = 0; eDone = 0;
    end else if (mFlushing || req) begin
      if (!mFlushing) begin
        mQ.delete();
        for (int a = 0; a < DEPTH; a++) mQ.push_back(a);
        mFlushing = 1;
      end
      if (mQ.size() == 0) begin
        mFlushing = 0;
        mInDone   = 1;
        eWen = 0; eBusy = 1; eDone = 1;
      end else if (hold) begin
        eWen = 0; eBusy = 1; eDone = 0;
      end else begin
        nextAddr = mQ.pop_front();
        eAddr = AW'(nextAddr);
        eData = FILL;
        eWen = 1; eBusy = 1; eDone = 0;
      end
    end else begin
      eWen = uw; eAddr = ua; eData = ud; eBusy = 0; eDone = 0;
    end
  endtask

  task automatic test_reset();
    reset_i = 1; flush_req_i = 0; flush_hold_i = 0;
    user_wen_i = 0; user_addr_i = '0; user_wdata_i = '0;
    tick();
    tick();
    checks++;
    if ({bram_wen_o, flush_busy_o, flush_done_o, user_stall_o} !== 4'b0000)
      $display("[TB] FAIL reset_ctrl: got %b expected 0000",
               {bram_wen_o, flush_busy_o, flush_done_o, user_stall_o});
    else passes++;
    checks++;
    if ({bram_addr_o, bram_wdata_o} !== '0)
      $display("[TB] FAIL reset_data: got addr %0h data %0h expected 0 0", bram_addr_o, bram_wdata_o);
    else passes++;
    reset_i = 0;
  endtask

  task automatic test_user_write();
    user_wen_i = 1; user_addr_i = 10'd5; user_wdata_i = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (user_stall_o !== 1'b0)
      $display("[TB] FAIL user_stall: got %b expected 0", user_stall_o);
    else passes++;
    tick();
    user_wen_i = 0;
    checks++;
    if ({bram_wen_o, bram_addr_o, bram_wdata_o} !== {1'b1, 10'd5, 32'hA5A5_A5A5})
      $display("[TB] FAIL user_write: got wen %b addr %0d data %h expected 1 5 a5a5a5a5",
               bram_wen_o, bram_addr_o, bram_wdata_o);
    else passes++;
    tick();
    checks++;
    if (bram_wen_o !== 1'b0)
      $display("[TB] FAIL user_idle: got wen %b expected 0", bram_wen_o);
    else passes++;
  endtask

  task automatic test_flush_basic();
    int busyCount = 0;
    bit seqOk = 1;
    flush_req_i = 1;
    tick();
    flush_req_i = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_busy_o) busyCount++;
      if (bram_wen_o !== 1'b1 || bram_addr_o !== AW'(i) || bram_wdata_o !== FILL || flush_done_o !== 1'b0) begin
        seqOk = 0;
        $display("[TB] FAIL flush_write_%0d: got wen %b addr %0d data %h done %b expected 1 %0d %h 0",
                 i, bram_wen_o, bram_addr_o, bram_wdata_o, flush_done_o, i, FILL);
      end
      tick();
    end
    checks++;
    if (!seqOk) $display("[TB] FAIL flush_sequence: got bad write sequence expected 0..15");
    else passes++;
    if (flush_busy_o) busyCount++;
    checks++;
    if ({flush_done_o, flush_busy_o, bram_wen_o} !== 3'b110)
      $display("[TB] FAIL flush_done: got done/busy/wen %b expected 110",
               {flush_done_o, flush_busy_o, bram_wen_o});
    else passes++;
    tick();
    if (flush_busy_o) busyCount++;
    checks++;
    if ({flush_done_o, flush_busy_o, bram_wen_o} !== 3'b000)
      $display("[TB] FAIL flush_after_done: got done/busy/wen %b expected 000",
               {flush_done_o, flush_busy_o, bram_wen_o});
    else passes++;
    checks++;
    if (busyCount !== DEPTH + 1)
      $display("[TB] FAIL flush_busy_len: got %0d expected %0d", busyCount, DEPTH + 1);
    else passes++;
  endtask

  task automatic test_hold();
    int span = 0, bubbles = 0, holdLeft = 0, lastAddr = -1;
    bit finished = 0, badBubble = 0, seqOk;
    int addrs[$];
    flush_req_i = 1; flush_hold_i = 0;
    tick();
    flush_req_i = 0;
    for (int c = 0; c < 60; c++) begin
      if (!flush_busy_o) begin
        finished = 1;
        break;
      end
      span++;
      if (bram_wen_o) begin
        addrs.push_back(int'(bram_addr_o));
        lastAddr = int'(bram_addr_o);
        if (bram_addr_o == AW'(6)) holdLeft = 3;
      end else if (!flush_done_o) begin
        bubbles++;
        if (lastAddr != 6) badBubble = 1;
      end
      flush_hold_i = (holdLeft > 0);
      if (holdLeft > 0) holdLeft--;
      tick();
    end
    flush_hold_i = 0;
    seqOk = (addrs.size() == DEPTH);
    for (int i = 0; i < addrs.size(); i++) if (addrs[i] != i) seqOk = 0;
    checks++;
    if (!finished) $display("[TB] FAIL hold_timeout: got busy after 60 cycles expected idle");
    else passes++;
    checks++;
    if (span !== DEPTH + 4) $display("[TB] FAIL hold_span: got %0d expected %0d", span, DEPTH + 4);
    else passes++;
    checks++;
    if (bubbles !== 3 || badBubble) $display("[TB] FAIL hold_bubbles: got %0d (misplaced %0d) expected 3 after addr 6", bubbles, badBubble);
    else passes++;
    checks++;
    if (!seqOk) $display("[TB] FAIL hold_sequence: got %0d writes not in order expected 0..15", addrs.size());
    else passes++;
  endtask

  task automatic test_req_with_user();
    bit doneSeen = 0;
    flush_req_i = 1; user_wen_i = 1; user_addr_i = 10'd3; user_wdata_i = 32'h1234_5678;
    #1;
    checks++;
    if (user_stall_o !== 1'b1) $display("[TB] FAIL collide_stall: got %b expected 1", user_stall_o);
    else passes++;
    tick();
    flush_req_i = 0; user_wen_i = 0;
    checks++;
    if ({bram_wen_o, bram_addr_o, bram_wdata_o} !== {1'b1, 10'd0, FILL})
      $display("[TB] FAIL collide_first: got wen %b addr %0d data %h expected 1 0 %h",
               bram_wen_o, bram_addr_o, bram_wdata_o, FILL);
    else passes++;
    for (int c = 0; c < 40; c++) begin
      if (flush_done_o) begin
        doneSeen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!doneSeen) $display("[TB] FAIL collide_done: got no done in 40 cycles expected done");
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid_flush();
    bit found = 0, doneSeen = 0, busySeen = 0;
    flush_req_i = 1;
    tick();
    flush_req_i = 0;
    for (int c = 0; c < 40; c++) begin
      if (bram_wen_o && bram_addr_o == AW'(8)) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) $display("[TB] FAIL midreset_reach: got no write to addr 8 expected one");
    else passes++;
    reset_i = 1;
    tick();
    reset_i = 0;
    checks++;
    if ({bram_wen_o, flush_busy_o, flush_done_o, bram_addr_o, bram_wdata_o} !== '0)
      $display("[TB] FAIL midreset_out: got wen %b busy %b done %b addr %0d data %h expected all 0",
               bram_wen_o, flush_busy_o, flush_done_o, bram_addr_o, bram_wdata_o);
    else passes++;
    for (int c = 0; c < 20; c++) begin
      if (flush_done_o) doneSeen = 1;
      if (flush_busy_o) busySeen = 1;
      tick();
    end
    checks++;
    if (doneSeen || busySeen)
      $display("[TB] FAIL midreset_quiet: got done %b busy %b expected 0 0", doneSeen, busySeen);
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit doneSeen = 0;
    flush_req_i = 1;
    tick();
    for (int i = 1; i < DEPTH + 1; i++) tick();
    checks++;
    if (flush_done_o !== 1'b1) $display("[TB] FAIL b2b_done: got %b expected 1", flush_done_o);
    else passes++;
    tick();
    checks++;
    if ({flush_busy_o, bram_wen_o, user_stall_o} !== 3'b001)
      $display("[TB] FAIL b2b_idle_gap: got busy/wen/stall %b expected 001",
               {flush_busy_o, bram_wen_o, user_stall_o});
    else passes++;
    tick();
    flush_req_i = 0;
    checks++;
    if ({flush_busy_o, bram_wen_o, bram_addr_o} !== {1'b1, 1'b1, 10'd0})
      $display("[TB] FAIL b2b_restart: got busy %b wen %b addr %0d expected 1 1 0",
               flush_busy_o, bram_wen_o, bram_addr_o);
    else passes++;
    for (int c = 0; c < 40; c++) begin
      if (flush_done_o) begin
        doneSeen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!doneSeen) $display("[TB] FAIL b2b_second_done: got no done in 40 cycles expected done");
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic expStall;
    reset_i = 1; flush_req_i = 0; flush_hold_i = 0; user_wen_i = 0;
    modelStep(1, 0, 0, 0, '0, '0);
    tick();
    for (int c = 0; c < 800; c++) begin
      reset_i      = ($urandom_range(0, 99) == 0);
      flush_req_i  = ($urandom_range(0, 9) == 0);
      flush_hold_i = ($urandom_range(0, 3) == 0);
      user_wen_i   = $urandom_range(0, 1);
      user_addr_i  = AW'($urandom);
      user_wdata_i = $urandom;
      #1;
      expStall = flush_req_i | eBusy;
      checks++;
      if (user_stall_o !== expStall)
        $display("[TB] FAIL rand_stall cycle %0d: got %b expected %b", c, user_stall_o, expStall);
      else passes++;
      modelStep(reset_i, flush_req_i, flush_hold_i, user_wen_i, user_addr_i, user_wdata_i);
      tick();
      checks++;
      if ({bram_wen_o, flush_busy_o, flush_done_o} !== {eWen, eBusy, eDone})
        $display("[TB] FAIL rand_ctrl cycle %0d: got wen/busy/done %b expected %b",
                 c, {bram_wen_o, flush_busy_o, flush_done_o}, {eWen, eBusy, eDone});
      else passes++;
      if (eWen) begin
        checks++;
        if ({bram_addr_o, bram_wdata_o} !== {eAddr, eData})
          $display("[TB] FAIL rand_write cycle %0d: got addr %0d data %h expected %0d %h",
                   c, bram_addr_o, bram_wdata_o, eAddr, eData);
        else passes++;
      end
    end
    reset_i = 0; flush_req_i = 0; flush_hold_i = 0; user_wen_i = 0;
  endtask

  initial begin
    test_reset();
    test_user_write();
    test_flush_basic();
    test_hold();
    test_req_with_user();
    test_reset_mid_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
